// File: rtl/rs_syndrome_calc.sv
// Streaming Reed-Solomon syndrome calculator over GF(2^M): Horner evaluation of
// S_j = r(alpha^j), j = 1..2T, one received symbol per cycle, highest degree first.
module rs_syndrome_calc #(
  parameter int           M         = 3,
  parameter int           T         = 2,
  parameter logic [M:0]   PRIM_POLY = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_symbol,
  output logic             syn_valid,
  input  logic             syn_ready,
  output logic [2*T*M-1:0] syndromes,
  output logic             error_flag
);

  localparam int N  = (1 << M) - 1;
  localparam int CW = $clog2(N);
  localparam int NS = 2 * T;

  // Handshakes: a transfer completes on a rising clk edge where valid and ready
  // are both high; enable=0 or reset=1 blocks every transfer.

  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  // Carry-less shift-and-add multiply, reduced modulo PRIM_POLY at every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    for (int i = 0; i < e; i++) v = xtime(v);
    return v;
  endfunction

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic            accept;
  logic            first;
  logic            last;

  assign in_ready   = enable && (state == ACCUM) && !reset;
  assign accept     = in_ready && in_valid;
  assign first      = (count == '0);
  assign last       = (count == CW'(N - 1));
  assign syn_valid  = (state == HOLD);
  assign error_flag = syn_valid && (syndromes != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && last) state_next = HOLD;
      HOLD:    if (enable && syn_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (accept) count <= last ? '0 : count + 1'b1;
  end

  // The first symbol of a codeword overwrites stale results, so no clear cycle.
  for (genvar g = 0; g < NS; g++) begin : g_acc
    localparam logic [M-1:0] ALPHA_J = alpha_pow(g + 1);
    logic [M-1:0] acc;

    always_ff @(posedge clk) begin
      if (reset)       acc <= '0;
      else if (accept) acc <= first ? in_symbol : (gf_mul(acc, ALPHA_J) ^ in_symbol);
    end

    assign syndromes[M*g +: M] = acc;
  end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc (RS(7,3) over GF(8)); reference syndromes come from
// direct evaluation sum r_i * alpha^(i*j) using log/antilog tables.
module tb_rs_syndrome_calc;

  localparam int M  = 3;
  localparam int T  = 2;
  localparam int N  = 7;
  localparam int SW = 2 * T * M;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_symbol;
  logic          syn_valid;
  logic          syn_ready;
  logic [SW-1:0] syndromes;
  logic          error_flag;

  int checks   = 0;
  int failures = 0;

  int alog [N];
  int glog [8];

  logic [SW-1:0] exp_q[$];

  rs_syndrome_calc #(.M(M), .T(T), .PRIM_POLY(4'b1011)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_symbol  (in_symbol),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syndromes  (syndromes),
    .error_flag (error_flag)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_tables();
    int v;
    v = 1;
    for (int e = 0; e < N; e++) begin
      alog[e] = v;
      glog[v] = e;
      v = v << 1;
      if (v >= 8) v = v ^ 'b1011;
    end
  endtask

  // cw[0] is r_6 (sent first), cw[6] is r_0 (sent last).
  function automatic logic [SW-1:0] model(input logic [M-1:0] cw [N]);
    logic [SW-1:0] res;
    int s;
    int deg;
    res = '0;
    for (int j = 1; j <= 2 * T; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) begin
        deg = N - 1 - k;
        if (cw[k] != 0) s = s ^ alog[(glog[cw[k]] + deg * j) % N];
      end
      res[M*(j-1) +: M] = M'(s);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: feed one codeword, optionally with random in_valid gaps and a
  // 3-cycle enable drop before symbol stall_at; then check the result.
  task automatic run_cw(input string tag, input logic [M-1:0] cw [N],
                        input bit rnd, input int stall_at, input int hold);
    int  i;
    int  guard;
    bit  stalled;
    bit  acc;
    logic [SW-1:0] exp;
    logic [SW-1:0] snap;
    exp_q.push_back(model(cw));
    syn_ready = (hold == 0);
    i = 0;
    guard = 0;
    stalled = 0;
    while (i < N) begin
      if (i == stall_at && !stalled) begin
        stalled = 1;
        enable = 1'b0;
        in_valid = 1'b1;
        in_symbol = ~cw[i];
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk({tag, " ready_when_disabled"}, 32'(in_ready), 0);
          tick();
        end
        enable = 1'b1;
      end
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_symbol = cw[i];
      @(negedge clk);
      acc = in_ready && in_valid;
      tick();
      if (acc) i++;
      guard++;
      if (guard > 200) begin
        chk({tag, " send_timeout"}, 1, 0);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    // Scoreboard: result must be present exactly one cycle after the Nth accept.
    exp = exp_q.pop_front();
    chk({tag, " syn_valid"}, 32'(syn_valid), 1);
    chk({tag, " in_ready_in_hold"}, 32'(in_ready), 0);
    chk({tag, " syndromes"}, 32'(syndromes), 32'(exp));
    chk({tag, " error_flag"}, 32'(error_flag), 32'(exp != 0));
    snap = syndromes;
    for (int c = 0; c < hold; c++) begin
      tick();
      chk({tag, " hold_valid"}, 32'(syn_valid), 1);
      chk({tag, " hold_stable"}, 32'(syndromes), 32'(snap));
      chk({tag, " hold_ready"}, 32'(in_ready), 0);
    end
    syn_ready = 1'b1;
    tick();
    chk({tag, " release_valid"}, 32'(syn_valid), 0);
    chk({tag, " release_ready"}, 32'(in_ready), 1);
    chk({tag, " kept_after_release"}, 32'(syndromes), 32'(exp));
  endtask

  logic [M-1:0] cw_zero [N];
  logic [M-1:0] cw_ones [N];
  logic [M-1:0] cw_r1   [N];
  logic [M-1:0] cw_r0   [N];
  logic [M-1:0] cw_rand [N];

  initial begin
    build_tables();
    for (int k = 0; k < N; k++) begin
      cw_zero[k] = '0;
      cw_ones[k] = 3'b001;
      cw_r1[k]   = '0;
      cw_r0[k]   = '0;
    end
    cw_r1[5] = 3'b001;
    cw_r0[6] = 3'b001;

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_symbol = '0; syn_ready = 1'b1;
    repeat (3) tick();
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst syn_valid", 32'(syn_valid), 0);
    reset = 1'b0;
    #1;
    chk("rst syndromes", 32'(syndromes), 0);
    chk("rst error_flag", 32'(error_flag), 0);
    chk("rst ready_after", 32'(in_ready), 1);

    // Fixed codewords from the plan, with hand-derived constants.
    run_cw("zeros", cw_zero, 0, -1, 0);
    chk("zeros const", 32'(syndromes), 32'h000);
    run_cw("ones", cw_ones, 0, -1, 0);
    chk("ones const", 32'(syndromes), 32'h000);
    run_cw("r1", cw_r1, 0, -1, 0);
    chk("r1 const", 32'(syndromes), 32'hCE2);
    run_cw("r0", cw_r0, 0, -1, 4);
    chk("r0 const", 32'(syndromes), 32'h249);

    // Same codewords with gapped valid and an enable drop mid-stream.
    run_cw("zeros_rnd", cw_zero, 1, 3, 0);
    run_cw("ones_rnd", cw_ones, 1, -1, 0);
    run_cw("r1_rnd", cw_r1, 1, 4, 1);
    chk("r1_rnd const", 32'(syndromes), 32'hCE2);
    run_cw("r0_rnd", cw_r0, 1, -1, 0);

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < N; k++) cw_rand[k] = M'($urandom_range(0, 7));
      run_cw("random", cw_rand, 1, (n % 2 == 0) ? int'($urandom_range(0, 6)) : -1,
             int'($urandom_range(0, 2)));
    end

    // Abort a partial codeword with reset; no residue may survive.
    in_valid = 1'b1;
    in_symbol = 3'b111;
    repeat (4) tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort ready_in_reset", 32'(in_ready), 0);
    @(negedge clk);
    chk("abort valid_in_reset", 32'(syn_valid), 0);
    tick();
    chk("abort valid_after_reset", 32'(syn_valid), 0);
    reset = 1'b0;
    run_cw("abort_zeros", cw_zero, 0, -1, 0);
    chk("abort const", 32'(syndromes), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
